// File: rtl/line_buffer_scaler.sv
// rtl/line_buffer_scaler.sv - triple-banked scanline store with horizontal pixel-repeat scaler
module line_buffer_scaler #(
    parameter int                 PIXEL_W     = 7,
    parameter int                 LINE_PIXELS = 160,
    parameter int                 SRC_XW      = 8,
    parameter int                 HSCALE      = 4,
    parameter int                 H_OFFSET    = 0,
    parameter logic [PIXEL_W-1:0] BORDER      = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [SRC_XW-1:0]  wr_x,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               wr_line_done,
    input  logic               rd_line_start,
    input  logic               rd_active,
    output logic [PIXEL_W-1:0] pix_out,
    output logic               pix_valid,
    output logic               line_fresh,
    output logic [7:0]         drop_count,
    output logic [7:0]         repeat_count
);
    localparam int AW    = $clog2(3 * LINE_PIXELS);
    localparam int IDX_W = $clog2(LINE_PIXELS + 1);
    localparam int PH_W  = (HSCALE > 1) ? $clog2(HSCALE) : 1;
    localparam int SK_W  = (H_OFFSET > 0) ? $clog2(H_OFFSET + 1) : 1;

    logic [PIXEL_W-1:0] r_mem [0:3*LINE_PIXELS-1];

    logic [1:0]         r_wr_bank;
    logic [1:0]         r_rd_bank;
    logic [1:0]         r_ready_bank;
    logic               r_ready;
    logic               r_primed;
    logic               r_line_fresh;
    logic [7:0]         r_drop_count;
    logic [7:0]         r_repeat_count;
    logic [SK_W-1:0]    r_skip;
    logic [PH_W-1:0]    r_phase;
    logic [IDX_W-1:0]   r_src_idx;
    logic [PIXEL_W-1:0] r_pix_out;
    logic               r_pix_valid;

    logic               w_wr_ok;
    logic [AW-1:0]      w_wr_addr;
    logic [AW-1:0]      w_rd_addr;
    logic [1:0]         w_free_bank;
    logic               w_take;
    logic               w_rd_ok;

    assign w_wr_ok     = wr_en && (32'(wr_x) < 32'(LINE_PIXELS));
    assign w_wr_addr   = AW'(r_wr_bank) * AW'(LINE_PIXELS) + AW'(wr_x);
    assign w_rd_addr   = AW'(r_rd_bank) * AW'(LINE_PIXELS) + AW'(r_src_idx);
    // Banks are 0,1,2, so the one used by neither side is 3 minus the other two.
    assign w_free_bank = 2'd3 - r_wr_bank - r_rd_bank;
    assign w_take      = rd_line_start && (r_ready || wr_line_done);
    assign w_rd_ok     = rd_active && !rd_line_start && (r_skip == '0)
                         && (32'(r_src_idx) < 32'(LINE_PIXELS)) && r_primed;

    // Storage is deliberately not reset; r_primed masks stale contents.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank      <= 2'd0;
            r_rd_bank      <= 2'd2;
            r_ready_bank   <= 2'd0;
            r_ready        <= 1'b0;
            r_primed       <= 1'b0;
            r_line_fresh   <= 1'b0;
            r_drop_count   <= 8'd0;
            r_repeat_count <= 8'd0;
        end else begin
            if (wr_line_done) begin
                if (r_ready && (r_drop_count != 8'hFF)) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
                r_ready_bank <= r_wr_bank;
                r_wr_bank    <= w_free_bank;
                r_primed     <= 1'b1;
            end

            if (w_take) begin
                r_ready <= 1'b0;
            end else if (wr_line_done) begin
                r_ready <= 1'b1;
            end

            if (rd_line_start) begin
                if (w_take) begin
                    r_rd_bank    <= wr_line_done ? r_wr_bank : r_ready_bank;
                    r_line_fresh <= 1'b1;
                end else begin
                    r_line_fresh <= 1'b0;
                    if (r_primed && (r_repeat_count != 8'hFF)) begin
                        r_repeat_count <= r_repeat_count + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip    <= '0;
            r_phase   <= '0;
            r_src_idx <= '0;
        end else if (rd_line_start) begin
            r_skip    <= SK_W'(H_OFFSET);
            r_phase   <= '0;
            r_src_idx <= '0;
        end else if (rd_active) begin
            if (r_skip != '0) begin
                r_skip <= r_skip - 1'b1;
            end else if (r_phase == PH_W'(HSCALE - 1)) begin
                r_phase <= '0;
                if (r_src_idx != IDX_W'(LINE_PIXELS)) begin
                    r_src_idx <= r_src_idx + 1'b1;
                end
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_out   <= BORDER;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= w_rd_ok;
            r_pix_out   <= w_rd_ok ? r_mem[w_rd_addr] : BORDER;
        end
    end

    assign pix_out      = r_pix_out;
    assign pix_valid    = r_pix_valid;
    assign line_fresh   = r_line_fresh;
    assign drop_count   = r_drop_count;
    assign repeat_count = r_repeat_count;
endmodule

// File: tb/tb_line_buffer_scaler.sv
// tb/tb_line_buffer_scaler.sv - directed bench with line-level reference model for line_buffer_scaler
module tb_line_buffer_scaler;
    localparam int LP   = 160;
    localparam int HS   = 4;
    localparam int HOFF = 0;
    localparam int NACT = 640;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_x = 8'd0;
    logic [6:0] wr_data = 7'd0;
    logic       wr_line_done = 1'b0;
    logic       rd_line_start = 1'b0;
    logic       rd_active = 1'b0;

    logic [6:0] pix_out,  pix_out2;
    logic       pix_valid, pix_valid2;
    logic       line_fresh, line_fresh2;
    logic [7:0] drop_count, drop_count2;
    logic [7:0] repeat_count, repeat_count2;

    line_buffer_scaler #(.PIXEL_W(7), .LINE_PIXELS(LP), .SRC_XW(8), .HSCALE(HS),
                         .H_OFFSET(HOFF), .BORDER(7'd0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_x(wr_x), .wr_data(wr_data),
        .wr_line_done(wr_line_done), .rd_line_start(rd_line_start), .rd_active(rd_active),
        .pix_out(pix_out), .pix_valid(pix_valid), .line_fresh(line_fresh),
        .drop_count(drop_count), .repeat_count(repeat_count));

    line_buffer_scaler #(.PIXEL_W(7), .LINE_PIXELS(LP), .SRC_XW(8), .HSCALE(HS),
                         .H_OFFSET(2), .BORDER(7'd0)) u_dut_off (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_x(wr_x), .wr_data(wr_data),
        .wr_line_done(wr_line_done), .rd_line_start(rd_line_start), .rd_active(rd_active),
        .pix_out(pix_out2), .pix_valid(pix_valid2), .line_fresh(line_fresh2),
        .drop_count(drop_count2), .repeat_count(repeat_count2));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: line contents per bank, scaler position from plain arithmetic.
    logic [6:0] mb [3][LP];
    int   m_wr, m_rd, m_rb, m_drop, m_rep, m_act;
    bit   m_ready, m_primed, m_fresh;
    logic [6:0] e_pix;
    bit   e_valid;

    initial begin
        int  k, done_b, nb;
        bit  vis, take;
        for (int b = 0; b < 3; b++)
            for (int x = 0; x < LP; x++) mb[b][x] = 7'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_wr = 0; m_rd = 2; m_rb = 0; m_drop = 0; m_rep = 0; m_act = 0;
                m_ready = 0; m_primed = 0; m_fresh = 0; e_pix = 7'd0; e_valid = 0;
            end else begin
                total++;
                if (pix_out !== e_pix || pix_valid !== e_valid || line_fresh !== m_fresh ||
                    drop_count !== 8'(m_drop) || repeat_count !== 8'(m_rep)) begin
                    bad++;
                    $display("FAIL model t=%0t got pix=%0d v=%0d f=%0d d=%0d r=%0d exp pix=%0d v=%0d f=%0d d=%0d r=%0d",
                             $time, pix_out, pix_valid, line_fresh, drop_count, repeat_count,
                             e_pix, e_valid, m_fresh, m_drop, m_rep);
                end
                vis = rd_active && !rd_line_start;
                e_valid = 0;
                e_pix = 7'd0;
                if (vis && m_primed && m_act >= HOFF) begin
                    k = (m_act - HOFF) / HS;
                    if (k < LP) begin
                        e_valid = 1;
                        e_pix = mb[m_rd][k];
                    end
                end
                if (vis) m_act++;
                if (wr_en && int'(wr_x) < LP) mb[m_wr][int'(wr_x)] = wr_data;
                take = rd_line_start && (m_ready || wr_line_done);
                if (wr_line_done) begin
                    if (m_ready && m_drop < 255) m_drop++;
                    done_b = m_wr;
                    nb = 0;
                    for (int b = 0; b < 3; b++)
                        if (b != done_b && b != m_rd) nb = b;
                    m_wr = nb;
                    m_rb = done_b;
                    m_ready = 1;
                    m_primed = 1;
                end
                if (rd_line_start) begin
                    m_act = 0;
                    if (take) begin
                        m_rd = m_rb;
                        m_ready = 0;
                        m_fresh = 1;
                    end else begin
                        m_fresh = 0;
                        if (m_primed && m_rep < 255) m_rep++;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [6:0] patf(input int p, input int x);
        int v;
        case (p)
            0:       v = x;
            1:       v = x ^ 'h55;
            2:       v = 127 - (x & 127);
            default: v = x * 3;
        endcase
        return 7'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input int p);
        for (int x = 0; x < LP; x++) begin
            wr_en = 1'b1; wr_x = 8'(x); wr_data = patf(p, x);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        wr_line_done = 1'b1; step(); wr_line_done = 1'b0;
    endtask

    task automatic start_line();
        rd_line_start = 1'b1; step(); rd_line_start = 1'b0;
    endtask

    logic [6:0] obs  [NACT];
    logic       obsv [NACT];
    logic [6:0] obs2 [NACT];
    logic       obsv2[NACT];
    int nvalid, nvalid2;

    task automatic read_line(input bit wr_during);
        nvalid = 0; nvalid2 = 0;
        for (int i = 0; i < NACT; i++) begin
            rd_active = 1'b1;
            if (wr_during) begin
                wr_en = 1'b1; wr_x = 8'(i % LP); wr_data = 7'h7F;
            end
            step();
            obs[i] = pix_out;   obsv[i] = pix_valid;
            obs2[i] = pix_out2; obsv2[i] = pix_valid2;
            if (pix_valid)  nvalid++;
            if (pix_valid2) nvalid2++;
        end
        rd_active = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        chk("reset_pix", int'(pix_out), 0);
        chk("reset_valid", int'(pix_valid), 0);
        chk("reset_fresh", int'(line_fresh), 0);
        chk("reset_drop", int'(drop_count), 0);
        chk("reset_repeat", int'(repeat_count), 0);
        rst_n = 1'b1;
        step();

        // no data yet: border only
        start_line();
        read_line(1'b0);
        chk("empty_nvalid", nvalid, 0);
        chk("empty_repeat", int'(repeat_count), 0);

        // first line, data = x
        write_line(0);
        pulse_done();
        start_line();
        read_line(1'b0);
        chk("l0_nvalid", nvalid, 640);
        chk("l0_fresh", int'(line_fresh), 1);
        chk("l0_first", int'(obs[0]), 0);
        chk("l0_k0_last", int'(obs[3]), 0);
        chk("l0_k1_first", int'(obs[4]), 1);
        chk("l0_last", int'(obs[639]), 31);
        chk("off_pre_valid", int'(obsv2[1]), 0);
        chk("off_first_valid", int'(obsv2[2]), 1);
        chk("off_first_pix", int'(obs2[2]), 0);
        chk("off_k1", int'(obs2[6]), 1);
        chk("off_nvalid", nvalid2, 638);

        // replay without a new line
        start_line();
        read_line(1'b0);
        chk("rep_fresh", int'(line_fresh), 0);
        chk("rep_count", int'(repeat_count), 1);
        chk("rep_k1", int'(obs[4]), 1);
        chk("rep_last", int'(obs[639]), 31);

        // two completed lines before a read: first one dropped
        write_line(1);
        pulse_done();
        write_line(2);
        pulse_done();
        chk("drop_one", int'(drop_count), 1);
        start_line();
        read_line(1'b0);
        chk("drop_first", int'(obs[0]), 127);
        chk("drop_k1", int'(obs[4]), 126);
        chk("drop_fresh", int'(line_fresh), 1);

        // simultaneous done/start, writes during readout
        write_line(3);
        wr_line_done = 1'b1; rd_line_start = 1'b1;
        step();
        wr_line_done = 1'b0; rd_line_start = 1'b0;
        read_line(1'b1);
        chk("sim_fresh", int'(line_fresh), 1);
        chk("sim_drop", int'(drop_count), 1);
        chk("sim_k10", int'(obs[40]), 30);
        chk("sim_last", int'(obs[639]), 93);

        // out-of-range writes ignored
        pulse_done();
        wr_en = 1'b1; wr_x = 8'd160; wr_data = 7'd0; step();
        wr_x = 8'd255; step();
        wr_en = 1'b0;
        pulse_done();
        chk("oob_drop", int'(drop_count), 2);
        start_line();
        read_line(1'b0);
        chk("oob_first", int'(obs[0]), 127);
        chk("oob_last", int'(obs[639]), 96);

        // reset in the middle of a line
        start_line();
        for (int i = 0; i < 10; i++) begin
            rd_active = 1'b1;
            step();
        end
        chk("pre_rst_valid", int'(pix_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pix", int'(pix_out), 0);
        chk("mid_rst_valid", int'(pix_valid), 0);
        chk("mid_rst_fresh", int'(line_fresh), 0);
        chk("mid_rst_drop", int'(drop_count), 0);
        chk("mid_rst_repeat", int'(repeat_count), 0);
        rd_active = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        start_line();
        read_line(1'b0);
        chk("post_rst_nvalid", nvalid, 0);
        chk("post_rst_repeat", int'(repeat_count), 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
